// File: rtl/effect_expander_if.sv
// Per-sample audio stream between the effects-chain sequencer and the expander stage.
// The master drives the sample strobe, controls and data; the slave returns the processed sample.
interface effect_expander_if;
    logic               i_valid;
    logic               i_enable;
    logic [2:0]         i_level;
    logic signed [15:0] i_data;
    logic signed [15:0] o_data;
    logic               o_valid;

    modport master (
        output i_valid, i_enable, i_level, i_data,
        input  o_data, o_valid
    );

    modport slave (
        input  i_valid, i_enable, i_level, i_data,
        output o_data, o_valid
    );
endinterface

// File: rtl/effect_expander.sv
// Downward expander / noise gate: envelope follower plus an attack/hold/release gain
// state machine that advances once per valid audio sample, with one cycle of latency.
module effect_expander #(
    parameter int ATTACK_SHIFT  = 4,
    parameter int RELEASE_SHIFT = 10,
    parameter int HOLD_SAMPLES  = 2400,
    parameter int ENV_SHIFT     = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    effect_expander_if.slave bus
);

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE,
        ST_CLOSED,
        ST_ATTACK
    } state_t;

    localparam int HC_W = ($clog2(HOLD_SAMPLES + 1) > 12) ? $clog2(HOLD_SAMPLES + 1) : 12;
    localparam logic [HC_W-1:0] HOLD_CNT = HC_W'(HOLD_SAMPLES);
    localparam logic [15:0] UNITY = 16'hFFFF;

    state_t          state;
    logic [15:0]     env;
    logic [15:0]     gain;
    logic [HC_W-1:0] hc;

    logic [15:0] thr_open;
    logic [15:0] thr_close;
    logic [15:0] floor_gain;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        thr_open   = 16'd200;
        floor_gain = 16'hC000;
        case (bus.i_level)
            3'd0: begin thr_open = 16'd200;  floor_gain = 16'hC000; end
            3'd1: begin thr_open = 16'd400;  floor_gain = 16'hA000; end
            3'd2: begin thr_open = 16'd600;  floor_gain = 16'h8000; end
            3'd3: begin thr_open = 16'd900;  floor_gain = 16'h6000; end
            3'd4: begin thr_open = 16'd1200; floor_gain = 16'h4000; end
            3'd5: begin thr_open = 16'd1600; floor_gain = 16'h2000; end
            3'd6: begin thr_open = 16'd2400; floor_gain = 16'h1000; end
            3'd7: begin thr_open = 16'd3200; floor_gain = 16'h0000; end
            default: ;
        endcase
        thr_close = thr_open - (thr_open >> 2);
    end

    // Envelope follower; -32768 saturates so the magnitude always fits 15 bits.
    logic [15:0]        abs_in;
    logic signed [16:0] env_diff;
    logic signed [16:0] env_step;
    logic signed [16:0] env_sum;
    logic [15:0]        env_next;

    always_comb begin
        if (bus.i_data == 16'sh8000) begin
            abs_in = 16'h7FFF;
        end else if (bus.i_data[15]) begin
            abs_in = 16'(-bus.i_data);
        end else begin
            abs_in = bus.i_data;
        end
        env_diff = signed'({1'b0, abs_in}) - signed'({1'b0, env});
        env_step = env_diff >>> ENV_SHIFT;
        env_sum  = signed'({1'b0, env}) + env_step;
        env_next = env_sum[15:0];
    end

    // Candidate gains for a rising (attack) and a floor-seeking (release) step.
    logic [15:0] gain_gap;
    logic [15:0] att_step;
    logic [16:0] att_sum;
    logic [15:0] gain_att;
    logic [15:0] rel_gap;
    logic [15:0] rel_step;
    logic [15:0] gain_rel;

    always_comb begin
        gain_gap = UNITY - gain;
        att_step = gain_gap >> ATTACK_SHIFT;
        if (att_step == 16'd0) att_step = 16'd1;
        att_sum  = {1'b0, gain} + {1'b0, att_step};
        gain_att = att_sum[16] ? UNITY : att_sum[15:0];

        rel_gap  = (gain > floor_gain) ? (gain - floor_gain) : (floor_gain - gain);
        rel_step = rel_gap >> RELEASE_SHIFT;
        if (rel_step == 16'd0) rel_step = 16'd1;
        if (gain == floor_gain) begin
            gain_rel = gain;
        end else if (gain > floor_gain) begin
            gain_rel = gain - rel_step;
        end else begin
            gain_rel = gain + rel_step;
        end
    end

    logic signed [32:0] data_ext;
    logic signed [32:0] gain_ext;
    logic signed [32:0] product;
    logic signed [15:0] out_sample;
    logic               unused_bits;

    always_comb begin
        data_ext = {{17{bus.i_data[15]}}, bus.i_data};
        gain_ext = {17'd0, gain};
        product  = data_ext * gain_ext;
        if (!bus.i_enable || gain == UNITY) begin
            out_sample = bus.i_data;
        end else begin
            out_sample = product[31:16];
        end
    end

    assign unused_bits = ^{product[32], product[15:0], env_sum[16]};

    // NOTE: registers use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_OPEN;
            env         <= 16'd0;
            gain        <= UNITY;
            hc          <= '0;
            bus.o_data  <= 16'sd0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                bus.o_data <= out_sample;
                env        <= env_next;
                if (!bus.i_enable) begin
                    state <= ST_OPEN;
                    gain  <= UNITY;
                    hc    <= '0;
                end else begin
                    case (state)
                        ST_OPEN: begin
                            gain <= UNITY;
                            if (env < thr_close) begin
                                state <= ST_HOLD;
                                hc    <= HOLD_CNT;
                            end
                        end
                        ST_ATTACK: begin
                            gain <= gain_att;
                            if (env < thr_close) begin
                                state <= ST_HOLD;
                                hc    <= HOLD_CNT;
                            end else if (gain_att == UNITY) begin
                                state <= ST_OPEN;
                            end
                        end
                        ST_HOLD: begin
                            if (env >= thr_open) begin
                                gain  <= gain_att;
                                state <= ST_ATTACK;
                            end else begin
                                hc <= hc - HC_W'(1);
                                if (hc == HC_W'(1)) state <= ST_RELEASE;
                            end
                        end
                        ST_RELEASE: begin
                            if (env >= thr_open) begin
                                gain  <= gain_att;
                                state <= ST_ATTACK;
                            end else begin
                                gain <= gain_rel;
                                if (gain_rel == floor_gain) state <= ST_CLOSED;
                            end
                        end
                        ST_CLOSED: begin
                            if (env >= thr_open) begin
                                gain  <= gain_att;
                                state <= ST_ATTACK;
                            end else if (gain != floor_gain) begin
                                state <= ST_RELEASE;
                            end
                        end
                        default: state <= ST_OPEN;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_effect_expander.sv
// Scoreboard bench for effect_expander: a behavioural model queues expected samples
// at issue time and a negedge monitor pops and compares them as outputs appear.
module tb_effect_expander;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    effect_expander_if bus ();

    effect_expander dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef enum {M_OPEN, M_HOLD, M_RELEASE, M_CLOSED, M_ATTACK} mst_t;
    typedef struct {
        int    val;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic exp_ovalid = 1'b0;

    int   t_tab[8] = '{200, 400, 600, 900, 1200, 1600, 2400, 3200};
    int   f_tab[8] = '{'hC000, 'hA000, 'h8000, 'h6000, 'h4000, 'h2000, 'h1000, 'h0000};

    int   m_env;
    int   m_g;
    int   m_hc;
    mst_t m_st;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: o_valid must mirror the strobe one edge late; each output pops one expectation.
    always @(posedge clk) exp_ovalid <= bus.i_valid & rst_n;

    always @(negedge clk) begin
        if (mon_en) begin
            check("o_valid", bus.o_valid, exp_ovalid);
            if (bus.o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0d, expected none", bus.o_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.tag, bus.o_data, e.val);
                end
            end
        end
    end

    function automatic int floor_div(input int v, input int d);
        int q;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int attack_gain(input int g);
        int st;
        st = (65535 - g) / 16;
        if (st < 1) st = 1;
        return (g + st > 65535) ? 65535 : g + st;
    endfunction

    task automatic model_reset();
        m_env = 0;
        m_g   = 65535;
        m_hc  = 0;
        m_st  = M_OPEN;
    endtask

    task automatic model_step(input int d, input bit en, input int lvl, output int y);
        int a, env_old, t, tc, f, gap, st;
        if (!en || m_g == 65535) y = d;
        else y = floor_div(d * m_g, 65536);
        a = (d == -32768) ? 32767 : ((d < 0) ? -d : d);
        env_old = m_env;
        m_env = m_env + floor_div(a - m_env, 128);
        if (!en) begin
            m_st = M_OPEN;
            m_g  = 65535;
            m_hc = 0;
            return;
        end
        t  = t_tab[lvl];
        tc = t - t / 4;
        f  = f_tab[lvl];
        case (m_st)
            M_OPEN: begin
                m_g = 65535;
                if (env_old < tc) begin m_st = M_HOLD; m_hc = 2400; end
            end
            M_ATTACK: begin
                m_g = attack_gain(m_g);
                if (env_old < tc) begin m_st = M_HOLD; m_hc = 2400; end
                else if (m_g == 65535) m_st = M_OPEN;
            end
            M_HOLD: begin
                if (env_old >= t) begin m_g = attack_gain(m_g); m_st = M_ATTACK; end
                else begin
                    m_hc = m_hc - 1;
                    if (m_hc == 0) m_st = M_RELEASE;
                end
            end
            M_RELEASE: begin
                if (env_old >= t) begin m_g = attack_gain(m_g); m_st = M_ATTACK; end
                else begin
                    gap = (m_g > f) ? m_g - f : f - m_g;
                    st  = gap / 1024;
                    if (st < 1) st = 1;
                    if (m_g > f) m_g = m_g - st;
                    else if (m_g < f) m_g = m_g + st;
                    if (m_g == f) m_st = M_CLOSED;
                end
            end
            M_CLOSED: begin
                if (env_old >= t) begin m_g = attack_gain(m_g); m_st = M_ATTACK; end
                else if (m_g != f) m_st = M_RELEASE;
            end
            default: m_st = M_OPEN;
        endcase
    endtask

    task automatic drive(input int d, input bit en, input int lvl, input int gap);
        bus.i_valid  = 1'b1;
        bus.i_enable = en;
        bus.i_level  = 3'(lvl);
        bus.i_data   = 16'(d);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input bit en, input int lvl, input int gap, input string tag);
        int y;
        exp_t e;
        model_step(d, en, lvl, y);
        e.val = y;
        e.tag = tag;
        exp_q.push_back(e);
        drive(d, en, lvl, gap);
    endtask

    // Hand-computed expectation; the model still advances so later samples stay aligned.
    task automatic send_x(input int d, input bit en, input int lvl, input int want, input string tag);
        int y;
        exp_t e;
        model_step(d, en, lvl, y);
        e.val = want;
        e.tag = tag;
        exp_q.push_back(e);
        drive(d, en, lvl, 0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_level  = 3'd7;
        bus.i_data   = 16'sd5000;
        model_reset();

        // Reset overrides a valid strobe in the same cycle.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_data", bus.o_data, 0);
        check("rst_o_valid", bus.o_valid, 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        send_x(5000, 1, 7, 5000, "first_after_reset");

        // Bypass at the hardest level, then re-enable from OPEN.
        for (int i = 0; i < 10000; i++) send_x(30, 0, 7, 30, "bypass");
        send_x(30, 1, 7, 30, "reenable_open");
        for (int i = 0; i < 5; i++) send(30, 1, 7, 0, "reenable_run");

        // Gate close: square wave drives env above 3200, then a quiet tail.
        n = 0;
        while (m_env <= 3200 && n < 2000) begin
            send(((n % 2) == 0) ? 10000 : -10000, 1, 7, 0, "gate_square");
            n++;
        end
        n = 0;
        while (m_st != M_CLOSED && n < 20000) begin
            send(100, 1, 7, 0, "gate_decay");
            n++;
        end
        repeat (5) send(100, 1, 7, 0, "gate_closed_run");
        send_x(100, 1, 7, 0, "gate_closed_pos");
        send_x(-100, 1, 7, 0, "gate_closed_neg");

        // Re-open with irregular idle gaps between strobes.
        for (int i = 0; i < 250; i++)
            send(((i % 2) == 0) ? 16000 : -16000, 1, 7, $urandom_range(1, 50), "reopen_gaps");
        send_x(16000, 1, 7, 16000, "reopen_unity_pos");
        send_x(-16000, 1, 7, -16000, "reopen_unity_neg");

        // Hysteresis band keeps OPEN; then re-attack from RELEASE.
        for (int i = 0; i < 1500; i++) send(2800, 1, 7, 0, "band");
        send_x(2800, 1, 7, 2800, "band_open");
        n = 0;
        while (m_st != M_RELEASE && n < 5000) begin
            send(100, 1, 7, 0, "to_release");
            n++;
        end
        repeat (500) send(100, 1, 7, 0, "in_release");
        n = 0;
        while (m_st != M_OPEN && n < 2000) begin
            send(10000, 1, 7, 0, "reattack");
            n++;
        end
        send_x(10000, 1, 7, 10000, "reattack_unity");

        // Full-scale negative input must not wrap the envelope.
        repeat (600) send(-32768, 1, 7, 0, "min_input");
        send_x(-32768, 1, 7, -32768, "min_unity");

        // Close at level 7, then switch to level 0 and ramp up to its floor.
        n = 0;
        while (m_st != M_CLOSED && n < 20000) begin
            send(100, 1, 7, 0, "close_lvl7");
            n++;
        end
        send(100, 1, 0, 0, "lvl0_start");
        n = 0;
        while (m_st != M_CLOSED && n < 20000) begin
            send(100, 1, 0, 0, "lvl0_ramp");
            n++;
        end
        send_x(100, 1, 0, 75, "lvl0_floor_pos");
        send_x(-100, 1, 0, -75, "lvl0_floor_neg");
        send_x(-32768, 1, 0, -24576, "lvl0_min_floor");
        send_x(-32768, 1, 0, -24576, "lvl0_attack_decide");
        send_x(-32768, 1, 0, -25088, "lvl0_attack_step");

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
